// File: rtl/pc_unit.sv
// pc_unit: program counter with next-PC selection, stall hold, redirect
// capture during stall, misaligned-target trap and exception PC register.
module pc_unit #(
    parameter int unsigned         WIDTH        = 32,
    parameter logic [WIDTH-1:0]    RESET_VECTOR = WIDTH'(32'h0000_0000),
    parameter logic [WIDTH-1:0]    EXC_VECTOR   = WIDTH'(32'h0000_0180),
    parameter int unsigned         ALIGN_BITS   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             exc_req,
    input  logic             jump_en,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             branch_en,
    input  logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic [WIDTH-1:0] epc,
    output logic             pend_valid,
    output logic             misalign
);

    // Sequential increment and the low-bit mask that a redirect target must clear.
    // An ALIGN_BITS of zero yields an increment of 1 and an all-zero mask.
    localparam logic [WIDTH-1:0] PC_INC     = WIDTH'(64'd1 << ALIGN_BITS);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    logic [WIDTH-1:0] pc_q,          pc_d;
    logic [WIDTH-1:0] epc_q,         epc_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;
    logic             pend_valid_q,  pend_valid_d;
    logic             misalign_q,    misalign_d;

    logic             cand_valid;
    logic [WIDTH-1:0] cand_target;
    logic             redir_valid;
    logic [WIDTH-1:0] redir_target;
    logic             redir_bad;

    // Sequential successor of the current PC, wrapping modulo 2**WIDTH.
    assign pc_plus = pc_q + PC_INC;

    // This cycle's redirect candidate: jump beats branch.
    always_comb begin
        cand_valid  = jump_en | branch_en;
        cand_target = jump_en ? jump_target : branch_target;
    end

    // Redirect applied on a non-stall edge: fresh candidate beats a held one.
    always_comb begin
        redir_valid  = cand_valid | pend_valid_q;
        redir_target = cand_valid ? cand_target : pend_target_q;
        redir_bad    = (redir_target & ALIGN_MASK) != '0;
    end

    // Next-state selection for PC, EPC, pending redirect and misalign pulse.
    always_comb begin
        pc_d          = pc_q;
        epc_d         = epc_q;
        pend_target_d = pend_target_q;
        pend_valid_d  = pend_valid_q;
        misalign_d    = 1'b0;

        if (exc_req) begin
            // Exceptions are never stalled and discard any held redirect.
            pc_d         = EXC_VECTOR;
            epc_d        = pc_q;
            pend_valid_d = 1'b0;
        end else if (stall) begin
            // Hold PC; remember the newest redirect seen while stalled.
            if (cand_valid) begin
                pend_target_d = cand_target;
                pend_valid_d  = 1'b1;
            end
        end else begin
            pend_valid_d = 1'b0;
            if (redir_valid) begin
                if (redir_bad) begin
                    pc_d       = EXC_VECTOR;
                    epc_d      = pc_q;
                    misalign_d = 1'b1;
                end else begin
                    pc_d = redir_target;
                end
            end else begin
                pc_d = pc_plus;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_VECTOR;
            epc_q         <= '0;
            pend_target_q <= '0;
            pend_valid_q  <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            epc_q         <= epc_d;
            pend_target_q <= pend_target_d;
            pend_valid_q  <= pend_valid_d;
            misalign_q    <= misalign_d;
        end
    end

    assign pc         = pc_q;
    assign epc        = epc_q;
    assign pend_valid = pend_valid_q;
    assign misalign   = misalign_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed checks of pc_unit at default parameters plus an
// 8-bit instance exercising PC wrap-around.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        exc_req;
    logic        jump_en;
    logic [31:0] jump_target;
    logic        branch_en;
    logic [31:0] branch_target;
    logic [31:0] pc, pc_plus, epc;
    logic        pend_valid, misalign;

    logic        rst_n_w;
    logic [7:0]  pc_w, pc_plus_w, epc_w;
    logic        pend_valid_w, misalign_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .exc_req       (exc_req),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .pc            (pc),
        .pc_plus       (pc_plus),
        .epc           (epc),
        .pend_valid    (pend_valid),
        .misalign      (misalign)
    );

    pc_unit #(
        .WIDTH        (8),
        .RESET_VECTOR (8'hF8),
        .EXC_VECTOR   (8'h80),
        .ALIGN_BITS   (2)
    ) dut_w (
        .clk           (clk),
        .rst_n         (rst_n_w),
        .stall         (1'b0),
        .exc_req       (1'b0),
        .jump_en       (1'b0),
        .jump_target   (8'h00),
        .branch_en     (1'b0),
        .branch_target (8'h00),
        .pc            (pc_w),
        .pc_plus       (pc_plus_w),
        .epc           (epc_w),
        .pend_valid    (pend_valid_w),
        .misalign      (misalign_w)
    );

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [31:0] e_pc,
                               input logic [31:0] e_epc, input logic e_pend,
                               input logic e_mis);
        check({tag, ".pc"},   pc,                  e_pc);
        check({tag, ".epc"},  epc,                 e_epc);
        check({tag, ".pend"}, {31'd0, pend_valid}, {31'd0, e_pend});
        check({tag, ".mis"},  {31'd0, misalign},   {31'd0, e_mis});
    endtask

    task automatic idle();
        stall = 0; exc_req = 0; jump_en = 0; branch_en = 0;
        jump_target = '0; branch_target = '0;
    endtask

    task automatic jump_to(input logic [31:0] t);
        jump_en = 1; jump_target = t;
        step();
        idle();
    endtask

    initial begin
        idle();
        rst_n   = 0;
        rst_n_w = 0;

        // Reset held for two edges, then sequential fetch.
        step(); step();
        check_state("reset", 32'h0, 32'h0, 1'b0, 1'b0);
        check("reset.pc_plus", pc_plus, 32'h4);
        rst_n = 1;
        step(); check("seq1", pc, 32'h4);
        step(); check("seq2", pc, 32'h8);
        step(); check("seq3", pc, 32'hC);
        check_state("seq3", 32'hC, 32'h0, 1'b0, 1'b0);
        step(); check("seq4", pc, 32'h10);

        // Jump beats branch.
        jump_en = 1; jump_target = 32'h200; branch_en = 1; branch_target = 32'h300;
        step(); idle();
        check("prio.jump", pc, 32'h200);
        check("prio.pc_plus", pc_plus, 32'h204);

        // Exception beats jump and branch in the same cycle.
        jump_to(32'h10);
        check("prio.back", pc, 32'h10);
        exc_req = 1; jump_en = 1; jump_target = 32'h200; branch_en = 1; branch_target = 32'h300;
        step(); idle();
        check_state("prio.exc", 32'h180, 32'h10, 1'b0, 1'b0);

        // Branch captured in the first of three stall cycles.
        jump_to(32'h20);
        stall = 1; branch_en = 1; branch_target = 32'h400;
        step(); branch_en = 0;
        check_state("stall1", 32'h20, 32'h10, 1'b1, 1'b0);
        step(); step();
        check_state("stall3", 32'h20, 32'h10, 1'b1, 1'b0);
        stall = 0;
        step();
        check_state("stall.rel", 32'h400, 32'h10, 1'b0, 1'b0);
        step(); check("stall.seq", pc, 32'h404);

        // Newer jump overwrites the older captured branch.
        jump_to(32'h20);
        stall = 1; branch_en = 1; branch_target = 32'h400;
        step(); branch_en = 0; jump_en = 1; jump_target = 32'h500;
        step(); jump_en = 0;
        step(); stall = 0;
        check("ovw.hold", pc, 32'h20);
        step();
        check_state("ovw.rel", 32'h500, 32'h10, 1'b0, 1'b0);

        // Exception during a stall drops the pending redirect.
        stall = 1; branch_en = 1; branch_target = 32'h600;
        step(); branch_en = 0;
        check("excst.pend", {31'd0, pend_valid}, 32'd1);
        exc_req = 1;
        step(); idle();
        check_state("excst.exc", 32'h180, 32'h500, 1'b0, 1'b0);
        step(); check("excst.seq", pc, 32'h184);

        // Misaligned jump traps, misalign pulses for one cycle.
        jump_to(32'h40);
        jump_en = 1; jump_target = 32'h102;
        step(); idle();
        check_state("mis.trap", 32'h180, 32'h40, 1'b0, 1'b1);
        step();
        check_state("mis.after", 32'h184, 32'h40, 1'b0, 1'b0);

        // Misaligned redirect held across a stall traps on release.
        stall = 1; branch_en = 1; branch_target = 32'h106;
        step(); branch_en = 0; stall = 0;
        check("mispend.hold", pc, 32'h184);
        step();
        check_state("mispend.trap", 32'h180, 32'h184, 1'b0, 1'b1);
        step();
        check("mispend.clr", {31'd0, misalign}, 32'd0);

        // Reset while stalled with a pending redirect.
        stall = 1; branch_en = 1; branch_target = 32'h700;
        step(); branch_en = 0;
        check("rstmid.pend", {31'd0, pend_valid}, 32'd1);
        rst_n = 0;
        step();
        check_state("rstmid.rst", 32'h0, 32'h0, 1'b0, 1'b0);
        rst_n = 1; stall = 0;
        step();
        check_state("rstmid.rel", 32'h4, 32'h0, 1'b0, 1'b0);

        // 8-bit instance wraps modulo 256.
        step();
        check("wrap.reset", {24'd0, pc_w}, 32'hF8);
        check("wrap.epc", {24'd0, epc_w}, 32'h0);
        check("wrap.flags", {30'd0, pend_valid_w, misalign_w}, 32'h0);
        rst_n_w = 1;
        step(); check("wrap.1", {24'd0, pc_w}, 32'hFC);
        check("wrap.pc_plus", {24'd0, pc_plus_w}, 32'h00);
        step(); check("wrap.2", {24'd0, pc_w}, 32'h00);
        step(); check("wrap.3", {24'd0, pc_w}, 32'h04);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program counter for the single-cycle core, replacing the bare PC register. It owns next-PC selection: sequential increment, branch, jump and exception redirect. It also provides stall hold, capture of redirects that arrive during a stall, misaligned-target trapping and an exception PC (EPC) register. It sits between the branch/jump control logic and the instruction memory address port.

Parameters:
WIDTH, 32, PC / target / EPC width in bits
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h0000_0180, PC value loaded on exception or misaligned target
ALIGN_BITS, 2, number of low PC bits that must be zero; increment = 2**ALIGN_BITS

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
stall  input  1  hold PC this cycle
exc_req  input  1  external exception request; never stalled
jump_en  input  1  unconditional jump redirect
jump_target  input  WIDTH  jump destination
branch_en  input  1  taken-branch redirect
branch_target  input  WIDTH  branch destination
pc  output  WIDTH  current PC (registered) to instruction memory
pc_plus  output  WIDTH  pc + 2**ALIGN_BITS (combinational, mod 2**WIDTH)
epc  output  WIDTH  PC of the instruction that trapped (registered)
pend_valid  output  1  a redirect captured during stall is waiting (registered)
misalign  output  1  one-cycle pulse: last accepted redirect target was misaligned (registered)

Behaviour:
- Clock is clk; reset is synchronous, active-low on rst_n. All state updates on the rising edge of clk.
- Reset (rst_n=0 at the edge): pc=RESET_VECTOR, epc=0, pend_valid=0, pending target=0, misalign=0. Reset overrides every other input, including during a stall with a pending redirect.
- Internal state: pc, epc, pend_valid, pend_target, misalign. No other FSM is required. The two effective modes are RUN (pend_valid=0) and HELD (pend_valid=1).
- Candidate redirect each cycle, in priority order:
  - jump_en → jump_target
  - else branch_en → branch_target
  - else none
- exc_req=1, regardless of stall:
  - pc ← EXC_VECTOR; epc ← current pc
  - pend_valid ← 0; misalign ← 0
  - Overrides jump, branch and any pending redirect.
- Else stall=1:
  - pc holds.
  - If a candidate exists, pend_target ← candidate and pend_valid ← 1. The newest candidate overwrites an older pending one.
  - Otherwise pending state holds.
  - misalign ← 0.
- Else stall=0, chosen target in priority order:
  - candidate if present
  - else pend_target if pend_valid
  - else pc_plus
- Alignment check: applies only to redirect targets (candidate or pending), not pc_plus.
  - If target[ALIGN_BITS-1:0] ≠ 0: pc ← EXC_VECTOR, epc ← current pc, misalign ← 1.
  - Otherwise pc ← target, misalign ← 0.
  - pend_valid ← 0 in both cases.
- ALIGN_BITS=0 disables the alignment check; the increment is then 1.
- Wrap-around: pc_plus and the sequential update are modulo 2**WIDTH; no overflow flag.
- Latency: a redirect is visible on pc exactly 1 cycle after it is accepted (non-stall edge). A redirect presented during a stall is visible 1 cycle after stall deasserts.
- epc changes only on exc_req or a misalign trap; otherwise it holds.
- Outputs contain no combinational paths from inputs except pc_plus, which depends on pc only.

Test Plan:
- Reset/sequential (WIDTH=32, defaults): hold rst_n=0 for 2 cycles, release → pc=0x0, then 0x4, 0x8, 0xC on successive edges; epc=0; pend_valid=0.
- Priority: at pc=0x10 assert jump_en (0x200) and branch_en (0x300) together, stall=0 → next pc=0x200. Same cycle with exc_req=1 → pc=0x180, epc=0x10.
- Stall capture: at pc=0x20, stall=1 for 3 cycles with branch_en (0x400) in cycle 1 only → pc stays 0x20, pend_valid=1. Deassert stall → pc=0x400, pend_valid=0. Repeat with jump 0x500 in stall cycle 2 → pc=0x500 (overwrite).
- Misalign: jump_target=0x102 at pc=0x40 → pc=0x180, epc=0x40, misalign=1 for exactly 1 cycle. Next cycle pc=0x184, misalign=0.
- Wrap: WIDTH=8, RESET_VECTOR=8'hF8 → pc sequence 0xF8, 0xFC, 0x00, 0x04.
- Reset mid-operation: with pend_valid=1 and stall=1, assert rst_n=0 for one edge → pc=RESET_VECTOR, pend_valid=0, epc=0. The pending target is never applied after release.
